mprj_pad_ctrl: RTL

MPRJ_PAD_CTRL -- requirements
Module: mprj_pad_ctrl

---
 rtl/mprj_pad_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mprj_pad_ctrl.sv
// User-project pad controller: per-pad shadow configuration, serial chain loader and
// staged pad-enable release after power-good. Define MPRJ_PAD_READBACK_EN to add a shadow readback port.
module mprj_pad_ctrl #(
  parameter int unsigned         NUM_PADS    = 38,
  parameter int unsigned         CFG_BITS    = 13,
  parameter logic [CFG_BITS-1:0] CFG_DEFAULT = CFG_BITS'(13'h0403),
  parameter int unsigned         GROUP_SIZE  = 8,
  parameter int unsigned         RELEASE_GAP = 16
) (
  input  logic                        clock,
  input  logic                        resetb,
  input  logic                        porb,
  input  logic                        cfg_wr_valid,
  output logic                        cfg_wr_ready,
  input  logic [$clog2(NUM_PADS)-1:0] cfg_wr_idx,
  input  logic [CFG_BITS-1:0]         cfg_wr_data,
  input  logic                        apply,
  output logic                        busy,
  output logic                        done,
  output logic                        serial_clock,
  output logic                        serial_data,
  output logic                        serial_load,
`ifdef MPRJ_PAD_READBACK_EN
  input  logic [$clog2(NUM_PADS)-1:0] cfg_rd_idx,
  output logic [CFG_BITS-1:0]         cfg_rd_data,
`endif
  output logic [NUM_PADS-1:0]         pad_enh
);

  localparam int unsigned IDX_W      = $clog2(NUM_PADS);
  localparam int unsigned BIT_W      = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
  localparam int unsigned NUM_GROUPS = (NUM_PADS + GROUP_SIZE - 1) / GROUP_SIZE;
  localparam int unsigned GRP_W      = $clog2(NUM_GROUPS + 1);
  localparam int unsigned GAP_W      = (RELEASE_GAP > 1) ? $clog2(RELEASE_GAP) : 1;

  typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LOAD, DONE} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     pad_q, pad_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic                 load_cnt_q, load_cnt_d;
  logic                 serial_data_d;
  logic                 wr_en;
  logic [CFG_BITS-1:0]  shadow_q [NUM_PADS];
  logic [CFG_BITS-1:0]  shadow_d [NUM_PADS];

  logic                 porb_m, porb_s;
  logic [GRP_W-1:0]     grp_q;
  logic [GAP_W-1:0]     gap_q;
  logic [NUM_PADS-1:0]  grp_mask;

  assign wr_en = cfg_wr_valid && cfg_wr_ready && (32'(cfg_wr_idx) < NUM_PADS);

  // Post-write shadow view so a write landing with apply feeds the first shifted bit
  always_comb begin
    shadow_d = shadow_q;
    if (wr_en) shadow_d[cfg_wr_idx] = cfg_wr_data;
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      for (int unsigned i = 0; i < NUM_PADS; i++) shadow_q[i] <= CFG_DEFAULT;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  // Serial chain sequencer: walks pad NUM_PADS-1 MSB down to pad 0 LSB
  always_comb begin
    state_d       = state_q;
    pad_d         = pad_q;
    bit_d         = bit_q;
    load_cnt_d    = 1'b0;
    serial_data_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        pad_d = IDX_W'(NUM_PADS - 1);
        bit_d = BIT_W'(CFG_BITS - 1);
        if (apply) state_d = SHIFT_LO;
      end
      SHIFT_LO: state_d = SHIFT_HI;
      SHIFT_HI: begin
        if (pad_q == '0 && bit_q == '0) begin
          state_d = LOAD;
        end else begin
          state_d = SHIFT_LO;
          if (bit_q == '0) begin
            bit_d = BIT_W'(CFG_BITS - 1);
            pad_d = pad_q - IDX_W'(1);
          end else begin
            bit_d = bit_q - BIT_W'(1);
          end
        end
      end
      LOAD: begin
        load_cnt_d = 1'b1;
        if (load_cnt_q) begin
          state_d    = DONE;
          load_cnt_d = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == SHIFT_LO)      serial_data_d = shadow_d[pad_d][bit_d];
    else if (state_d == SHIFT_HI) serial_data_d = serial_data;
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q      <= IDLE;
      pad_q        <= '0;
      bit_q        <= '0;
      load_cnt_q   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      serial_clock <= 1'b0;
      serial_data  <= 1'b0;
      serial_load  <= 1'b0;
      cfg_wr_ready <= 1'b1;
    end else begin
      state_q      <= state_d;
      pad_q        <= pad_d;
      bit_q        <= bit_d;
      load_cnt_q   <= load_cnt_d;
      busy         <= (state_d != IDLE);
      done         <= (state_d == DONE);
      serial_clock <= (state_d == SHIFT_HI);
      serial_data  <= serial_data_d;
      serial_load  <= (state_d == LOAD);
      cfg_wr_ready <= (state_d == IDLE);
    end
  end

  always_comb begin
    grp_mask = '0;
    for (int unsigned i = 0; i < NUM_PADS; i++) grp_mask[i] = ((i / GROUP_SIZE) == 32'(grp_q));
  end

  // Staged enable release: group 0 immediately after porb_s goes high, then one group per gap
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      porb_m  <= 1'b0;
      porb_s  <= 1'b0;
      grp_q   <= '0;
      gap_q   <= '0;
      pad_enh <= '0;
    end else begin
      porb_m <= porb;
      porb_s <= porb_m;
      if (!porb_s) begin
        pad_enh <= '0;
        grp_q   <= '0;
        gap_q   <= '0;
      end else if (32'(grp_q) < NUM_GROUPS) begin
        if (grp_q == '0 || 32'(gap_q) == RELEASE_GAP - 1) begin
          pad_enh <= pad_enh | grp_mask;
          grp_q   <= grp_q + GRP_W'(1);
          gap_q   <= '0;
        end else begin
          gap_q <= gap_q + GAP_W'(1);
        end
      end
    end
  end

`ifdef MPRJ_PAD_READBACK_EN
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb)                           cfg_rd_data <= '0;
    else if (32'(cfg_rd_idx) < NUM_PADS)   cfg_rd_data <= shadow_q[cfg_rd_idx];
    else                                   cfg_rd_data <= '0;
  end
`endif

endmodule
